// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM arbiter: FSM state encoding, the registered RAM
// command bundle and a one-hot to index helper used by the round-robin pointer.
package ram_arb_pkg;

  // Default byte address width; the arbiter's ADDRESS_WIDTH must equal it
  localparam int RAM_ARB_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [RAM_ARB_ADDR_W-1:0] address;
    logic                      rd;
    logic                      wr;
    logic [3:0]                byte_enable;
    logic [31:0]               data_wr;
  } ram_cmd_t;

  // Index of the set bit in a one-hot vector of up to 8 requesters
  function automatic int onehot_index(input logic [7:0] onehot);
    int idx;
    idx = 0;
    for (int k = 0; k < 8; k++) begin
      idx = onehot[k] ? k : idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/ram_arbiter_picker.sv
// Combinational winner selection for the RAM arbiter.
// With RAM_ARB_RR_EN defined the search starts one past the pointer
// (round-robin); otherwise the lowest active index wins.
module arb_picker
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] active,
`ifdef RAM_ARB_RR_EN
  input  logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] ptr,
`endif
  output logic [NUM_REQ-1:0] winner
);

`ifdef RAM_ARB_RR_EN
  int   best_s;
  int   win_s;
  int   dist_s;
  logic take_s;
  logic found_s;

  // Pick the active requester with the smallest rotated distance from ptr+1
  always_comb begin
    best_s  = NUM_REQ;
    win_s   = 0;
    dist_s  = 0;
    take_s  = 1'b0;
    winner  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dist_s = (i + NUM_REQ - 1 - int'(ptr)) % NUM_REQ;
      take_s = active[i] && (dist_s < best_s);
      best_s = take_s ? dist_s : best_s;
      win_s  = take_s ? i : win_s;
    end
    found_s = (best_s < NUM_REQ);
    for (int i = 0; i < NUM_REQ; i++) begin
      winner[i] = found_s && (win_s == i);
    end
  end
`else
  // Isolate the lowest set bit of the active vector
  always_comb begin
    winner = active & (~active + {{(NUM_REQ-1){1'b0}}, 1'b1});
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM port between NUM_REQ cache-side requesters,
// one outstanding transaction at a time, with a per-requester lock that keeps
// the grant across a burst. Define RAM_ARB_RR_EN for round-robin selection;
// the default build uses fixed priority (lowest index wins).
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = RAM_ARB_ADDR_W,
  parameter int NUM_REQ       = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0][ADDRESS_WIDTH-1:0]  req_address,
  input  logic [NUM_REQ-1:0]                     req_rd,
  input  logic [NUM_REQ-1:0]                     req_wr,
  input  logic [NUM_REQ-1:0][3:0]                req_byte_enable,
  input  logic [NUM_REQ-1:0][31:0]               req_data_wr,
  input  logic [NUM_REQ-1:0]                     req_lock,
  output logic [NUM_REQ-1:0]                     req_ready,
  output logic [31:0]                            req_data_rd,
  output logic [NUM_REQ-1:0]                     grant,
  output logic [ADDRESS_WIDTH-1:0]               ram_address,
  output logic                                   ram_rd,
  output logic                                   ram_wr,
  output logic [3:0]                             ram_byte_enable,
  output logic [31:0]                            ram_data_wr,
  input  logic [31:0]                            ram_data_rd,
  input  logic                                   ram_ready
);

  arb_state_t         state_r;
  arb_state_t         state_s;
  logic [NUM_REQ-1:0] grant_r;
  logic [NUM_REQ-1:0] grant_s;
  logic [NUM_REQ-1:0] active_s;
  logic [NUM_REQ-1:0] pick_s;
  logic [NUM_REQ-1:0] sel_s;
  logic               owner_active_s;
  logic               owner_lock_s;
  ram_cmd_t           cmd_r;
  ram_cmd_t           cmd_s;
  ram_cmd_t           sel_cmd_s;

  assign active_s       = req_rd | req_wr;
  assign owner_active_s = |(active_s & grant_r);
  assign owner_lock_s   = |(req_lock & grant_r);

`ifdef RAM_ARB_RR_EN
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr_r;
  logic             take_s;

  assign take_s = (state_r == IDLE) && (|active_s);

  // Remember the last requester granted from IDLE; reset makes requester 0 first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= PTR_W'(NUM_REQ - 1);
    end else if (take_s) begin
      ptr_r <= PTR_W'(onehot_index(8'(pick_s)));
    end
  end

  arb_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .active (active_s),
    .ptr    (ptr_r),
    .winner (pick_s)
  );
`else
  arb_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .active (active_s),
    .winner (pick_s)
  );
`endif

  // Mux the selected requester's command; a write wins over a simultaneous read
  always_comb begin
    if (state_r == LOCKED) begin
      sel_s = grant_r;
    end else begin
      sel_s = pick_s;
    end
    sel_cmd_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_cmd_s.address     = sel_cmd_s.address     | (req_address[i]     & {ADDRESS_WIDTH{sel_s[i]}});
      sel_cmd_s.byte_enable = sel_cmd_s.byte_enable | (req_byte_enable[i] & {4{sel_s[i]}});
      sel_cmd_s.data_wr     = sel_cmd_s.data_wr     | (req_data_wr[i]     & {32{sel_s[i]}});
      sel_cmd_s.rd          = sel_cmd_s.rd          | (req_rd[i] & sel_s[i]);
      sel_cmd_s.wr          = sel_cmd_s.wr          | (req_wr[i] & sel_s[i]);
    end
    sel_cmd_s.rd = sel_cmd_s.rd & ~sel_cmd_s.wr;
  end

  // Next state, next grant and next RAM command
  always_comb begin
    state_s = state_r;
    grant_s = grant_r;
    cmd_s   = cmd_r;
    case (state_r)
      IDLE: begin
        if (|active_s) begin
          grant_s = pick_s;
          cmd_s   = sel_cmd_s;
          state_s = BUSY;
        end else begin
          grant_s = '0;
        end
      end
      BUSY: begin
        if (ram_ready) begin
          cmd_s.rd = 1'b0;
          cmd_s.wr = 1'b0;
          if (owner_lock_s) begin
            state_s = LOCKED;
          end else begin
            state_s = IDLE;
            grant_s = '0;
          end
        end else begin
          state_s = BUSY;
        end
      end
      LOCKED: begin
        if (owner_active_s) begin
          cmd_s   = sel_cmd_s;
          state_s = BUSY;
        end else if (!owner_lock_s) begin
          state_s = IDLE;
          grant_s = '0;
        end else begin
          state_s = LOCKED;
        end
      end
      default: begin
        state_s = IDLE;
        grant_s = '0;
        cmd_s   = '0;
      end
    endcase
  end

  // State, grant and RAM command registers; reset abandons any outstanding access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      grant_r <= '0;
      cmd_r   <= '0;
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
      cmd_r   <= cmd_s;
    end
  end

  // Completion pulse to the owner only while a command is outstanding
  always_comb begin
    if ((state_r == BUSY) && ram_ready) begin
      req_ready = grant_r;
    end else begin
      req_ready = '0;
    end
  end

  assign req_data_rd     = ram_data_rd;
  assign grant           = grant_r;
  assign ram_address     = cmd_r.address;
  assign ram_rd          = cmd_r.rd;
  assign ram_wr          = cmd_r.wr;
  assign ram_byte_enable = cmd_r.byte_enable;
  assign ram_data_wr     = cmd_r.data_wr;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter. Requesters are modelled as queues of
// operations; a transaction-level reference model predicts ownership, the
// outstanding command and completions every cycle. Works with or without
// RAM_ARB_RR_EN.
module tb_ram_arbiter;

  localparam int N  = 2;
  localparam int AW = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [N-1:0][AW-1:0]  req_address;
  logic [N-1:0]          req_rd;
  logic [N-1:0]          req_wr;
  logic [N-1:0][3:0]     req_byte_enable;
  logic [N-1:0][31:0]    req_data_wr;
  logic [N-1:0]          req_lock;
  logic [N-1:0]          req_ready;
  logic [31:0]           req_data_rd;
  logic [N-1:0]          grant;
  logic [AW-1:0]         ram_address;
  logic                  ram_rd;
  logic                  ram_wr;
  logic [3:0]            ram_byte_enable;
  logic [31:0]           ram_data_wr;
  logic [31:0]           ram_data_rd = 32'h0;
  logic                  ram_ready   = 1'b0;

  ram_arbiter dut (
    .clk(clk), .rst(rst),
    .req_address(req_address), .req_rd(req_rd), .req_wr(req_wr),
    .req_byte_enable(req_byte_enable), .req_data_wr(req_data_wr),
    .req_lock(req_lock), .req_ready(req_ready), .req_data_rd(req_data_rd),
    .grant(grant), .ram_address(ram_address), .ram_rd(ram_rd), .ram_wr(ram_wr),
    .ram_byte_enable(ram_byte_enable), .ram_data_wr(ram_data_wr),
    .ram_data_rd(ram_data_rd), .ram_ready(ram_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [31:0]   data;
    bit            rd;
    bit            wr;
    bit            lock;
  } op_t;

  op_t          q [N][$];
  int           tests  = 0;
  int           failed = 0;
  int           owner  = -1;
  bit           outst  = 1'b0;
  int           last   = N - 1;
  op_t          cur;
  int           obs_order[$];
  bit           prev_strobe = 1'b0;
  logic [N-1:0] last_rdy;
  logic [31:0]  last_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic op_t mk(logic [AW-1:0] a, logic [3:0] be, logic [31:0] d, bit rd, bit wr, bit lk);
    op_t o;
    o.addr = a; o.be = be; o.data = d; o.rd = rd; o.wr = wr; o.lock = lk;
    return o;
  endfunction

  function automatic op_t rand_op();
    int t;
    t = $urandom_range(0, 2);
    return mk(AW'($urandom), 4'($urandom), 32'($urandom), t != 1, t != 0, $urandom_range(0, 3) == 0);
  endfunction

  // Arbitration rule from IDLE, stated over requester indices
  function automatic int pick(logic [N-1:0] act);
`ifdef RAM_ARB_RR_EN
    for (int k = 1; k <= N; k++) begin
      if (act[(last + k) % N]) return (last + k) % N;
    end
`else
    for (int i = 0; i < N; i++) begin
      if (act[i]) return i;
    end
`endif
    return -1;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0) begin
        req_address[i] = q[i][0].addr;  req_byte_enable[i] = q[i][0].be;
        req_data_wr[i] = q[i][0].data;  req_rd[i] = q[i][0].rd;
        req_wr[i]      = q[i][0].wr;    req_lock[i] = q[i][0].lock;
      end else begin
        req_address[i] = '0; req_byte_enable[i] = '0; req_data_wr[i] = '0;
        req_rd[i] = 1'b0; req_wr[i] = 1'b0; req_lock[i] = 1'b0;
      end
    end
  endtask

  // One clock cycle: drive, check at negedge against the model, advance model
  task automatic tick(input bit rdy, input logic [31:0] rdata);
    logic [N-1:0] act, lk, eg, er;
    int w, gi;
    drive_reqs();
    ram_ready   = rdy;
    ram_data_rd = rdata;
    @(negedge clk);
    eg = '0;
    if (owner >= 0) eg[owner] = 1'b1;
    er = '0;
    if (outst && rdy) er[owner] = 1'b1;
    chk("grant", 64'(grant), 64'(eg));
    chk("ram_rd", 64'(ram_rd), 64'(outst && cur.rd && !cur.wr));
    chk("ram_wr", 64'(ram_wr), 64'(outst && cur.wr));
    if (outst) begin
      chk("ram_address", 64'(ram_address), 64'(cur.addr));
      chk("ram_be", 64'(ram_byte_enable), 64'(cur.be));
      chk("ram_data_wr", 64'(ram_data_wr), 64'(cur.data));
    end
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("req_data_rd", 64'(req_data_rd), 64'(rdata));
    gi = -1;
    for (int i = 0; i < N; i++) if (grant[i]) gi = i;
    if ((ram_rd || ram_wr) && !prev_strobe) obs_order.push_back(gi);
    prev_strobe = ram_rd || ram_wr;
    last_rdy    = req_ready;
    last_rdata  = req_data_rd;
    for (int i = 0; i < N; i++) begin
      act[i] = q[i].size() > 0;
      lk[i]  = act[i] && q[i][0].lock;
    end
    if (outst) begin
      if (rdy) begin
        outst = 1'b0;
        if (!lk[owner]) owner = -1;
      end
    end else if (owner >= 0) begin
      if (act[owner]) begin
        outst = 1'b1;
        cur   = q[owner][0];
      end else if (!lk[owner]) begin
        owner = -1;
      end
    end else begin
      w = pick(act);
      if (w >= 0) begin
        owner = w; outst = 1'b1; cur = q[w][0]; last = w;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (req_ready[i] && q[i].size() > 0) void'(q[i].pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  // Assert reset mid-cycle, check outputs clear at once, release after an edge
  task automatic do_reset();
    #2;
    for (int i = 0; i < N; i++) q[i].delete();
    drive_reqs();
    rst = 1'b1;
    ram_ready = 1'b1;
    #1;
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_ram_rd", 64'(ram_rd), 64'(0));
    chk("rst_ram_wr", 64'(ram_wr), 64'(0));
    chk("rst_ram_address", 64'(ram_address), 64'(0));
    chk("rst_ram_be", 64'(ram_byte_enable), 64'(0));
    chk("rst_ram_data_wr", 64'(ram_data_wr), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    owner = -1; outst = 1'b0; last = N - 1; prev_strobe = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ram_ready = 1'b0;
  endtask

  task automatic drain(input bit rnd, input int budget);
    int n;
    bit pend, r;
    n = 0;
    pend = 1'b1;
    while (pend && n < budget) begin
      r = rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
      tick(r, 32'($urandom));
      n++;
      pend = 1'b0;
      for (int i = 0; i < N; i++) if (q[i].size() > 0) pend = 1'b1;
    end
    chk("drain_timeout", 64'(pend), 64'(0));
    tick(1'b0, 32'($urandom));
    tick(1'b0, 32'($urandom));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_o[$];
    drive_reqs();
    do_reset();

    // Single read, ready three cycles after issue
    q[0].push_back(mk(16'h0010, 4'hF, 32'h0, 1'b1, 1'b0, 1'b0));
    tick(1'b0, 32'h0);
    chk("read_issue", 64'(ram_rd), 64'(1));
    repeat (3) tick(1'b0, 32'h0);
    tick(1'b1, 32'hDEADBEEF);
    chk("read_ready", 64'(last_rdy), 64'(2'b01));
    chk("read_data", 64'(last_rdata), 64'(32'hDEADBEEF));
    tick(1'b0, 32'h0);
    chk("read_grant_clear", 64'(grant), 64'(0));
    chk("read_strobe_clear", 64'(ram_rd), 64'(0));

    // Write from requester 1, held until ready
    do_reset();
    q[1].push_back(mk(16'h0123, 4'b0011, 32'h12345678, 1'b0, 1'b1, 1'b0));
    tick(1'b0, 32'h0);
    tick(1'b0, 32'h0);
    tick(1'b0, 32'h0);
    chk("wr_held_wr", 64'(ram_wr), 64'(1));
    chk("wr_held_rd", 64'(ram_rd), 64'(0));
    chk("wr_held_be", 64'(ram_byte_enable), 64'(4'b0011));
    chk("wr_held_data", 64'(ram_data_wr), 64'(32'h12345678));
    chk("wr_grant", 64'(grant), 64'(2'b10));
    tick(1'b1, 32'h0);
    tick(1'b0, 32'h0);

    // Read and write together becomes a write
    q[0].push_back(mk(16'h0200, 4'hF, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b0));
    tick(1'b0, 32'h0);
    chk("conflict_wr", 64'(ram_wr), 64'(1));
    chk("conflict_rd", 64'(ram_rd), 64'(0));
    tick(1'b1, 32'h0);
    tick(1'b0, 32'h0);

    // Reset during BUSY, then a stray ready, then a fresh request
    q[0].push_back(mk(16'h0300, 4'hF, 32'h0, 1'b1, 1'b0, 1'b0));
    tick(1'b0, 32'h0);
    do_reset();
    tick(1'b1, 32'h55AA55AA);
    chk("stray_ready", 64'(last_rdy), 64'(0));
    q[1].push_back(mk(16'h0044, 4'hF, 32'h0, 1'b1, 1'b0, 1'b0));
    tick(1'b0, 32'h0);
    chk("post_rst_issue", 64'(ram_rd), 64'(1));
    chk("post_rst_addr", 64'(ram_address), 64'(16'h0044));
    tick(1'b1, 32'h0);
    tick(1'b0, 32'h0);

    // Both requesters, four reads each
    do_reset();
    obs_order.delete();
    for (int k = 0; k < 4; k++) begin
      q[0].push_back(mk(AW'(16'h1000 + k), 4'hF, 32'h0, 1'b1, 1'b0, 1'b0));
      q[1].push_back(mk(AW'(16'h2000 + k), 4'hF, 32'h0, 1'b1, 1'b0, 1'b0));
    end
    drain(1'b0, 100);
`ifdef RAM_ARB_RR_EN
    exp_o = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_o = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
    chk("order_len", 64'(obs_order.size()), 64'(exp_o.size()));
    foreach (exp_o[i]) if (i < obs_order.size()) chk("order", 64'(obs_order[i]), 64'(exp_o[i]));

    // Locked four-word fill from requester 0 while requester 1 waits
    do_reset();
    obs_order.delete();
    for (int k = 0; k < 4; k++) q[0].push_back(mk(AW'(16'h3000 + 4 * k), 4'hF, 32'h0, 1'b1, 1'b0, k != 3));
    q[1].push_back(mk(16'h4000, 4'hF, 32'h0, 1'b1, 1'b0, 1'b0));
    drain(1'b0, 100);
    exp_o = '{0, 0, 0, 0, 1};
    chk("lock_len", 64'(obs_order.size()), 64'(exp_o.size()));
    foreach (exp_o[i]) if (i < obs_order.size()) chk("lock_order", 64'(obs_order[i]), 64'(exp_o[i]));

    // Randomized traffic with random latency, locks and stray ready pulses
    do_reset();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        int cnt;
        cnt = $urandom_range(0, 6);
        for (int k = 0; k < cnt; k++) q[i].push_back(rand_op());
      end
      drain(1'b1, 600);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares one external RAM port between NUM_REQ cache-side requesters, e.g. an instruction and a data direct-mapped cache, each speaking the cache RAM interface (address, rd/wr strobes, byte enables, write data, ready). It holds one outstanding RAM transaction at a time and picks a winner when idle. It supports a per-requester lock so that a line fill or write-back burst is never interleaved with another requester's accesses. It sits between the caches and the RAM controller.

## Interface
- ADDRESS_WIDTH, 16, byte address width; must match the caches.
- NUM_REQ, 2, number of requesters; range 2..8.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_address  in  [NUM_REQ][ADDRESS_WIDTH]  per-requester address
- req_rd, req_wr  in  [NUM_REQ]  per-requester read/write strobes, held until req_ready
- req_byte_enable  in  [NUM_REQ][4]  per-requester byte enables
- req_data_wr  in  [NUM_REQ][32]  per-requester write data
- req_lock  in  [NUM_REQ]  keep the grant after the current access completes
- req_ready  out  [NUM_REQ]  completion pulse, granted requester only
- req_data_rd  out  32  read data broadcast to all requesters; valid when req_ready[g]
- grant  out  [NUM_REQ]  one-hot current owner; all-zero when idle
- ram_address  out  ADDRESS_WIDTH  registered command to RAM
- ram_rd, ram_wr  out  1  registered strobes
- ram_byte_enable  out  4  registered byte enables
- ram_data_wr  out  32  registered write data
- ram_data_rd  in  32  RAM read data
- ram_ready  in  1  single-cycle completion from RAM

## Operation
- State machine states:
  - IDLE: no owner.
  - BUSY: command on the RAM bus, waiting for ram_ready.
  - LOCKED: owner retained, no command outstanding.
- IDLE:
  - A requester is active when req_rd[i] or req_wr[i] is high.
  - If any requester is active, pick winner g, register its address, byte enables, data and strobes onto ram_*, set grant[g], and go to BUSY.
- Strobe conflict: if req_rd and req_wr are both high, issue a write (ram_wr=1, ram_rd=0).
- BUSY:
  - ram_* and grant are held stable.
  - When ram_ready=1: req_ready[g]=1 in the same cycle (combinational), and req_data_rd passes ram_data_rd through.
  - At the next edge, ram_rd and ram_wr go to 0.
  - Next state is LOCKED if req_lock[g]=1 in the ready cycle, else IDLE; grant clears in IDLE.
- LOCKED:
  - Only requester g is considered; others stall.
  - If g is active, issue its command and go to BUSY.
  - Else if req_lock[g]=0, go to IDLE.
  - Else stay in LOCKED.
- ram_ready while in IDLE or LOCKED is ignored; req_ready stays 0.
- req_data_rd is driven by ram_data_rd at all times; it is meaningful only with req_ready.
- A requester updates its request at the edge where it samples req_ready. The arbiter therefore evaluates the updated request in the following cycle.

## Timing
- Reset values:
  - All outputs 0, state IDLE, grant 0.
  - Priority pointer set to NUM_REQ-1, so requester 0 wins first.
- Issue latency: request high in cycle 0 in IDLE -> ram_rd/ram_wr high in cycle 1.
- Completion: ram_ready in cycle k -> req_ready[g] in cycle k; strobes low in cycle k+1.
- Back-to-back: the earliest next ram strobe is cycle k+2, with one idle bus cycle. The same holds in LOCKED.
- Reset asserted mid-BUSY: outputs clear immediately and the outstanding RAM access is abandoned. A late ram_ready after reset release is ignored.
- Requests arriving while BUSY wait; they are not queued beyond the held strobes.

## Configuration
- RAM_ARB_RR_EN defined: round-robin.
  - The search starts at last_grant+1, modulo NUM_REQ.
  - The pointer updates when a grant is taken from IDLE.
- RAM_ARB_RR_EN undefined: fixed priority; the lowest index wins. The pointer register is removed.
- LOCKED behaviour is identical in both builds.

## Structure
- Package ram_arb_pkg holds:
  - arb_state_t enum (IDLE, BUSY, LOCKED).
  - ram_cmd_t struct (address, rd, wr, byte_enable, data_wr), with ADDRESS_WIDTH as a package constant default.
- Sub-module arb_picker: combinational. It takes the active vector and the pointer and returns the one-hot winner; it holds the RR/fixed logic.

## Test plan
- Single read, req 0 addr 0x0010, ram_ready 3 cycles after issue with data 0xDEADBEEF -> ram_rd high in cycle 1, req_ready[0] with 0xDEADBEEF, grant 0 afterwards.
- Both requesting together, four accesses each, with RR_EN -> grants alternate 0,1,0,1,...; without RR_EN -> all of req 0 first.
- Req 0 fill of 4 words with req_lock=1 and req 1 active throughout -> four req 0 accesses uninterrupted, then req 1 is granted after lock drops.
- Write, req 1 with be=4'b0011 and data 0x12345678 -> ram_wr=1 with identical be and data held until ram_ready, ram_rd=0.
- rd and wr both high -> a write is issued.
- Reset asserted during BUSY, then a stray ram_ready -> outputs 0 immediately, no req_ready, next request issues normally.
